// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// The request struct is sized for the 4096x32 data SRAM.
package dmem_pkg;

    localparam int DMEM_ADDR_W    = 12;
    localparam int DMEM_DATA_W    = 32;
    localparam int NUM_LEGAL_STRB = 7;

    // Single bytes, aligned halfwords and the full word are the only strobes the wrapper can steer.
    localparam logic [3:0] LEGAL_STRB [NUM_LEGAL_STRB] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
    };

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } dmem_req_id_t;

    typedef struct packed {
        logic                   write;
        logic [3:0]             wstrb;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    function automatic logic wstrb_legal(input logic [3:0] strb);
        logic legal;
        legal = 1'b0;
        for (int i = 0; i < NUM_LEGAL_STRB; i++) begin
            legal |= (strb == LEGAL_STRB[i]);
        end
        return legal;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Core/DMA arbiter in front of the single-port data SRAM: fixed core priority with DMA
// anti-starvation, one access per cycle, responses routed back two cycles after the handshake.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_write,
    input  logic [3:0]        core_req_wstrb,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,
    output logic              core_rsp_err,

    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_write,
    input  logic [3:0]        dma_req_wstrb,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_rdata,
    output logic              dma_rsp_err,

    output logic              data_enable,
    output logic              data_read,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_fetch
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]   starve_q, starve_d;
    logic         starved;
    logic         any_grant;
    dmem_req_id_t win_id;
    dmem_req_t    win_req;
    logic         win_err;

    logic         s1_valid_q;
    dmem_req_id_t s1_id_q;
    dmem_req_t    s1_req_q;
    logic         s1_err_q;
    logic         s1_write;

    logic         s2_valid_q;
    dmem_req_id_t s2_id_q;
    logic         s2_err_q;
    logic         s2_load_q;

    // Core wins unless DMA has been stalled STARVE_MAX cycles in a row.
    always_comb begin
        starved        = (starve_q == STARVE_LIM);
        core_req_ready = core_req_valid & ~(dma_req_valid & starved);
        dma_req_ready  = dma_req_valid & (~core_req_valid | starved);
        any_grant      = core_req_ready | dma_req_ready;

        starve_d = starve_q;
        if (!dma_req_valid || dma_req_ready) begin
            starve_d = '0;
        end else if (!starved) begin
            starve_d = starve_q + 4'd1;
        end

        win_id = dma_req_ready ? REQ_DMA : REQ_CORE;
        if (dma_req_ready) begin
            win_req.write = dma_req_write;
            win_req.wstrb = dma_req_wstrb;
            win_req.addr  = dma_req_addr;
            win_req.wdata = dma_req_wdata;
        end else begin
            win_req.write = core_req_write;
            win_req.wstrb = core_req_wstrb;
            win_req.addr  = core_req_addr;
            win_req.wdata = core_req_wdata;
        end
        win_err = win_req.write & ~wstrb_legal(win_req.wstrb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Issue stage: the SRAM address and data hold across idle cycles, only the valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= REQ_CORE;
            s1_req_q   <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= any_grant;
            if (any_grant) begin
                s1_id_q  <= win_id;
                s1_req_q <= win_req;
                s1_err_q <= win_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_id_q    <= REQ_CORE;
            s2_err_q   <= 1'b0;
            s2_load_q  <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_err_q   <= s1_err_q;
            s2_load_q  <= s1_valid_q & ~s1_req_q.write & ~s1_err_q;
        end
    end

    assign s1_write    = s1_valid_q & s1_req_q.write;
    assign data_enable = s1_valid_q & ~s1_err_q;
    assign data_read   = ~s1_write;
    assign mem_wstrb   = s1_write ? s1_req_q.wstrb : 4'b1111;
    assign ram_address = s1_req_q.addr;
    assign ram_store   = s1_req_q.wdata;

    // ram_fetch is only meaningful for a non-error load that was issued the cycle before.
    assign core_rsp_valid = s2_valid_q & (s2_id_q == REQ_CORE);
    assign dma_rsp_valid  = s2_valid_q & (s2_id_q == REQ_DMA);
    assign core_rsp_err   = core_rsp_valid & s2_err_q;
    assign dma_rsp_err    = dma_rsp_valid & s2_err_q;
    assign core_rsp_rdata = (core_rsp_valid & s2_load_q) ? ram_fetch : '0;
    assign dma_rsp_rdata  = (dma_rsp_valid & s2_load_q) ? ram_fetch : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: an SRAM model sits behind the DUT, a reference memory
// and arbitration model predict every ready and every response, and a scoreboard matches them.
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        core_req_valid, core_req_ready, core_req_write;
    logic [3:0]  core_req_wstrb;
    logic [11:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_rsp_valid, core_rsp_err;
    logic [31:0] core_rsp_rdata;

    logic        dma_req_valid, dma_req_ready, dma_req_write;
    logic [3:0]  dma_req_wstrb;
    logic [11:0] dma_req_addr;
    logic [31:0] dma_req_wdata;
    logic        dma_rsp_valid, dma_rsp_err;
    logic [31:0] dma_rsp_rdata;

    logic        data_enable, data_read;
    logic [3:0]  mem_wstrb;
    logic [11:0] ram_address;
    logic [31:0] ram_store;
    bit   [31:0] ram_fetch;

    bit   [31:0] sram   [4096];
    bit   [31:0] refMem [4096];

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int starveModel = 0;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [3:0]  wstrb;
        logic [11:0] addr;
        logic [31:0] wdata;
    } tbReq_t;

    typedef struct {
        logic        isDma;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } expRsp_t;

    expRsp_t sbQ[$];
    expRsp_t headRsp;

    localparam tbReq_t NOREQ = '0;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_write(core_req_write), .core_req_wstrb(core_req_wstrb),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .core_rsp_err(core_rsp_err),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_write(dma_req_write), .dma_req_wstrb(dma_req_wstrb),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
        .dma_rsp_err(dma_rsp_err),
        .data_enable(data_enable), .data_read(data_read), .mem_wstrb(mem_wstrb),
        .ram_address(ram_address), .ram_store(ram_store), .ram_fetch(ram_fetch)
    );

    // Free-running 100 MHz clock and a cycle counter used to time scoreboard entries.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // The wrapper steers low-aligned store data onto the lanes picked by the strobe.
    function automatic logic [31:0] applyStore(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] strb);
        int          sh;
        logic [31:0] steered;
        logic [31:0] res;
        sh = 0;
        for (int i = 3; i >= 0; i--) if (strb[i]) sh = i;
        steered = wd << (8 * sh);
        res = old;
        for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = steered[8*i +: 8];
        return res;
    endfunction

    function automatic logic tbStrbLegal(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic tbReq_t mkReq(input logic wr, input logic [3:0] strb,
                                     input logic [11:0] addr, input logic [31:0] wd);
        tbReq_t r;
        r.valid = 1'b1;
        r.write = wr;
        r.wstrb = strb;
        r.addr  = addr;
        r.wdata = wd;
        return r;
    endfunction

    // Behavioural single-port SRAM: read data appears the cycle after the read is clocked.
    always @(posedge clk) begin
        if (data_enable) begin
            if (data_read) ram_fetch <= sram[ram_address];
            else sram[ram_address] <= applyStore(sram[ram_address], ram_store, mem_wstrb);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Predict the response for a granted request and keep the reference memory in issue order.
    task automatic pushExpect(input logic isDma, input tbReq_t r);
        expRsp_t e;
        e.isDma = isDma;
        e.err   = r.write & ~tbStrbLegal(r.wstrb);
        e.rdata = r.write ? 32'h0 : refMem[r.addr];
        e.due   = cycleCount + 2;
        if (r.write && !e.err) refMem[r.addr] = applyStore(refMem[r.addr], r.wdata, r.wstrb);
        sbQ.push_back(e);
    endtask

    task automatic setInputs(input tbReq_t c, input tbReq_t d);
        core_req_valid = c.valid;
        core_req_write = c.write;
        core_req_wstrb = c.wstrb;
        core_req_addr  = c.addr;
        core_req_wdata = c.wdata;
        dma_req_valid  = d.valid;
        dma_req_write  = d.write;
        dma_req_wstrb  = d.wstrb;
        dma_req_addr   = d.addr;
        dma_req_wdata  = d.wdata;
    endtask

    // Present one cycle of requests, check both readies against the arbitration model, then
    // queue the predicted response for whichever side the model says wins.
    task automatic applyStimulus(input tbReq_t c, input tbReq_t d,
                                 output logic cSeen, output logic dSeen);
        logic starved, expC, expD;
        setInputs(c, d);
        @(negedge clk);
        starved = (starveModel == 4);
        expC = c.valid & ~(d.valid & starved);
        expD = d.valid & (~c.valid | starved);
        cSeen = core_req_ready;
        dSeen = dma_req_ready;
        checkOutput("core_req_ready", core_req_ready, expC);
        checkOutput("dma_req_ready", dma_req_ready, expD);
        if (expC) pushExpect(1'b0, c);
        if (expD) pushExpect(1'b1, d);
        if (!d.valid || expD) starveModel = 0;
        else if (!starved) starveModel++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic cs, ds;
        for (int i = 0; i < n; i++) applyStimulus(NOREQ, NOREQ, cs, ds);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_data_enable", data_enable, 1'b0);
        checkOutput("rst_data_read", data_read, 1'b1);
        checkOutput("rst_mem_wstrb", mem_wstrb, 4'b1111);
        checkOutput("rst_ram_address", ram_address, 12'h0);
        checkOutput("rst_ram_store", ram_store, 32'h0);
        checkOutput("rst_core_rsp_valid", core_rsp_valid, 1'b0);
        checkOutput("rst_dma_rsp_valid", dma_rsp_valid, 1'b0);
        checkOutput("rst_core_rsp_rdata", core_rsp_rdata, 32'h0);
        checkOutput("rst_dma_rsp_rdata", dma_rsp_rdata, 32'h0);
        checkOutput("rst_core_rsp_err", core_rsp_err, 1'b0);
        checkOutput("rst_dma_rsp_err", dma_rsp_err, 1'b0);
    endtask

    // Response checker: a due scoreboard entry must appear on exactly its owner's port,
    // and on every other cycle both response ports must stay quiet.
    always @(negedge clk) begin
        if (sbQ.size() > 0 && sbQ[0].due == cycleCount) begin
            headRsp = sbQ.pop_front();
            checkOutput("core_rsp_valid", core_rsp_valid, !headRsp.isDma);
            checkOutput("dma_rsp_valid", dma_rsp_valid, headRsp.isDma);
            checkOutput("core_rsp_rdata", core_rsp_rdata, headRsp.isDma ? 32'h0 : headRsp.rdata);
            checkOutput("dma_rsp_rdata", dma_rsp_rdata, headRsp.isDma ? headRsp.rdata : 32'h0);
            checkOutput("core_rsp_err", core_rsp_err, !headRsp.isDma & headRsp.err);
            checkOutput("dma_rsp_err", dma_rsp_err, headRsp.isDma & headRsp.err);
        end else begin
            checkOutput("idle_core_rsp_valid", core_rsp_valid, 1'b0);
            checkOutput("idle_dma_rsp_valid", dma_rsp_valid, 1'b0);
        end
    end

    // Directed sequence covering reset, read-after-write, starvation, illegal strobes,
    // byte lanes, alternating traffic and mid-flight resets.
    initial begin
        tbReq_t     coreHold, dmaHold;
        logic       cs, ds;
        logic [5:0] coreSeq, dmaSeq;
        bit   [31:0] saved;

        setInputs(NOREQ, NOREQ);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus(mkReq(1'b1, 4'b1111, 12'h010, 32'hDEADBEEF), NOREQ, cs, ds);
        applyStimulus(mkReq(1'b0, 4'b0000, 12'h010, 32'h0), NOREQ, cs, ds);
        idle(3);

        coreHold = mkReq(1'b0, 4'b0000, 12'h100, 32'h0);
        dmaHold  = mkReq(1'b0, 4'b0000, 12'h200, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(coreHold, dmaHold, cs, ds);
            coreSeq[i] = cs;
            dmaSeq[i]  = ds;
            if (cs) coreHold = mkReq(1'b0, 4'b0000, 12'(12'h101 + i), 32'h0);
            if (ds) dmaHold = mkReq(1'b0, 4'b0000, 12'h201, 32'h0);
        end
        checkOutput("starve_core_grants", coreSeq, 6'b101111);
        checkOutput("starve_dma_grants", dmaSeq, 6'b010000);
        idle(3);

        applyStimulus(NOREQ, mkReq(1'b1, 4'b0101, 12'h010, 32'h12345678), cs, ds);
        #2 checkOutput("bad_strb_no_enable", data_enable, 1'b0);
        idle(2);
        applyStimulus(mkReq(1'b0, 4'b0000, 12'h010, 32'h0), NOREQ, cs, ds);
        idle(3);

        applyStimulus(mkReq(1'b1, 4'b0100, 12'h020, 32'h000000AB), NOREQ, cs, ds);
        #2;
        checkOutput("byte_data_enable", data_enable, 1'b1);
        checkOutput("byte_data_read", data_read, 1'b0);
        checkOutput("byte_mem_wstrb", mem_wstrb, 4'b0100);
        checkOutput("byte_ram_address", ram_address, 12'h020);
        checkOutput("byte_ram_store", ram_store, 32'h000000AB);
        applyStimulus(mkReq(1'b0, 4'b0000, 12'h020, 32'h0), NOREQ, cs, ds);
        applyStimulus(NOREQ, mkReq(1'b1, 4'b0001, 12'h020, 32'h000000CD), cs, ds);
        applyStimulus(NOREQ, mkReq(1'b0, 4'b0000, 12'h020, 32'h0), cs, ds);
        idle(3);

        for (int i = 0; i < 8; i++)
            applyStimulus(NOREQ, mkReq(1'b1, 4'b1111, 12'(12'h300 + i), 32'hA5000000 | i), cs, ds);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(mkReq(1'b0, 4'b0000, 12'(12'h300 + i), 32'h0), NOREQ, cs, ds);
            else applyStimulus(NOREQ, mkReq(1'b0, 4'b0000, 12'(12'h300 + i), 32'h0), cs, ds);
        end
        idle(3);

        // Reset with a load in S1 and a store in S2: neither responds.
        applyStimulus(mkReq(1'b1, 4'b1111, 12'h040, 32'hCAFEF00D), NOREQ, cs, ds);
        applyStimulus(mkReq(1'b0, 4'b0000, 12'h040, 32'h0), NOREQ, cs, ds);
        setInputs(NOREQ, NOREQ);
        #1 rst_n = 1'b0;
        sbQ.delete();
        starveModel = 0;
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // Reset with a store in S1: the store must never reach the SRAM.
        saved = refMem[12'h050];
        applyStimulus(NOREQ, mkReq(1'b1, 4'b1111, 12'h050, 32'h0BADF00D), cs, ds);
        setInputs(NOREQ, NOREQ);
        #1 rst_n = 1'b0;
        sbQ.delete();
        starveModel = 0;
        refMem[12'h050] = saved;
        #1 checkOutput("rst_s1_write_blocked", data_enable, 1'b0);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(mkReq(1'b0, 4'b0000, 12'h050, 32'h0), NOREQ, cs, ds);
        applyStimulus(NOREQ, mkReq(1'b0, 4'b0000, 12'h040, 32'h0), cs, ds);
        idle(4);

        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
